core_fetch: RTL

- Instruction fetch stage directly upstream of decode/dispatch.
- Fetches aligned pairs of 32-bit instructions from the instruction bus and buffers them in a small prefetch FIFO.
- Presents one pair per cycle (slot a = older, slot b = younger) with PCs and valid bits; holds output under `stall`.
- On `flush`, discards all buffered and in-flight instructions and restarts at `target`.

---
 rtl/core_fetch_pkg.sv | 26 ++
 rtl/core_fetch_fifo.sv | 47 ++++
 rtl/core_fetch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/core_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package core_fetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PTR_W  = 30;
    localparam int unsigned PAIR_W = 29;

    typedef logic [PTR_W-1:0]  ptr;
    typedef logic [PAIR_W-1:0] pair_ptr;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] insn_a;
        logic [XLEN-1:0] insn_b;
        pair_ptr         pc;
        logic            skip_a;
    } fetch_entry;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_WAIT,
        BUS_DROP
    } bus_state;

endpackage

// File: rtl/core_fetch_fifo.sv
// Prefetch FIFO of instruction pairs; only the pointers and count are reset.
module core_fetch_fifo
    import core_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  fetch_entry    push_data,
    output logic [CW-1:0] count,
    output fetch_entry    head
);

    fetch_entry    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointer and occupancy tracking; clear drops everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch stage: pair requests on the instruction bus, prefetch
// buffering, and a registered two-slot output toward decode.
module core_fetch
    import core_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter ptr          RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  ptr                target,
    input  logic              stall,
    input  logic              insn_ready,
    input  logic [2*XLEN-1:0] insn_data,
    output logic              insn_start,
    output pair_ptr           insn_addr,
    output logic [XLEN-1:0]   insn_a,
    output logic [XLEN-1:0]   insn_b,
    output ptr                pc_a,
    output ptr                pc_b,
    output logic              valid_a,
    output logic              valid_b
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;

    bus_state      state;
    bus_state      state_nxt;
    ptr            fetch_ptr;
    pair_ptr       req_pc;
    logic          req_skip;
    logic          run;
    logic [CW-1:0] fifo_count;
    fetch_entry    fifo_head;
    fetch_entry    resp_entry;
    fetch_entry    load_entry;
    logic          outstanding;
    logic          has_room;
    logic          accept;
    logic          load;
    logic          bypass;
    logic          fifo_push;
    logic          fifo_pop;
    logic          load_valid;

    // Room counts the in-flight request as an occupied slot.
    assign outstanding = (state != BUS_IDLE);
    assign has_room    = ({1'b0, fifo_count} + CW1'(outstanding)) < CW1'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BUS_IDLE;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
        end
    end

    // Bus FSM: WAIT holds a live request, DROP holds one orphaned by a flush.
    always_comb begin
        state_nxt  = state;
        insn_start = 1'b0;
        accept     = 1'b0;
        case (state)
            BUS_IDLE: begin
                if (run && !flush && has_room) begin
                    insn_start = 1'b1;
                    state_nxt  = BUS_WAIT;
                end
            end
            BUS_WAIT: begin
                if (flush) begin
                    state_nxt = insn_ready ? BUS_IDLE : BUS_DROP;
                end else if (insn_ready) begin
                    accept = 1'b1;
                    if (has_room) begin
                        insn_start = 1'b1;
                        state_nxt  = BUS_WAIT;
                    end else begin
                        state_nxt  = BUS_IDLE;
                    end
                end
            end
            BUS_DROP: begin
                if (insn_ready) state_nxt = BUS_IDLE;
            end
            default: state_nxt = BUS_IDLE;
        endcase
    end

    assign insn_addr = fetch_ptr[PTR_W-1:1];

    // Fetch pointer and the attributes of the request currently on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_ptr <= RESET_PC;
            req_pc    <= '0;
            req_skip  <= 1'b0;
        end else if (flush) begin
            fetch_ptr <= target;
        end else if (insn_start) begin
            req_pc    <= fetch_ptr[PTR_W-1:1];
            req_skip  <= fetch_ptr[0];
            fetch_ptr <= {fetch_ptr[PTR_W-1:1] + PAIR_W'(1), 1'b0};
        end
    end

    assign resp_entry.insn_a = insn_data[XLEN-1:0];
    assign resp_entry.insn_b = insn_data[2*XLEN-1:XLEN];
    assign resp_entry.pc     = req_pc;
    assign resp_entry.skip_a = req_skip;

    // An empty FIFO lets the bus response go straight into the output register.
    assign load       = !stall || !valid_b;
    assign bypass     = (fifo_count == '0);
    assign load_entry = bypass ? resp_entry : fifo_head;
    assign load_valid = !bypass || accept;
    assign fifo_pop   = !flush && load && !bypass;
    assign fifo_push  = accept && !(load && bypass);

    core_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (flush),
        .push_data (resp_entry),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Output register toward decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_a  <= NOP;
            insn_b  <= NOP;
            pc_a    <= '0;
            pc_b    <= '0;
            valid_a <= 1'b0;
            valid_b <= 1'b0;
        end else if (flush) begin
            valid_a <= 1'b0;
            valid_b <= 1'b0;
        end else if (load) begin
            if (load_valid) begin
                insn_a  <= load_entry.skip_a ? NOP : load_entry.insn_a;
                insn_b  <= load_entry.insn_b;
                pc_a    <= {load_entry.pc, 1'b0};
                pc_b    <= {load_entry.pc, 1'b1};
                valid_a <= !load_entry.skip_a;
                valid_b <= 1'b1;
            end else begin
                valid_a <= 1'b0;
                valid_b <= 1'b0;
            end
        end
    end

endmodule
